harmonic_sequencer: RTL and testbench
=====================================

HARMONIC_SEQUENCER -- requirements
Module: harmonic_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_INTERVAL, default 1000, clock cycles per output sample (48 MHz / 48 kHz).
REQ-002 SHALL have parameter NO_OF_HARMONICS, default 100, maximum harmonic count per sample.
REQ-003 SHALL have parameter WAIT_TIMEOUT, default 255, maximum cycles spent in any single wait state.
REQ-004 SHALL have ports: i_Clock  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have ports: i_Reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: i_Enable  in  1  frame start permitted; i_Harmonic_Limit  in  8  requested harmonic count.
REQ-007 SHALL have ports: i_Scaler_Ready  in  2  odd/even scaler done; i_Sample_Ready  in  1  sine lookup valid; i_Freq_Too_High  in  1  current harmonic above Nyquist.
REQ-008 SHALL have ports: o_Harmonic  out  8  current index; o_Next_Sample, o_Scaler_Restart, o_Adder_Clear, o_Total_Latch, o_DAC_Send  out  1 each  single-cycle strobes.
REQ-009 SHALL have ports: o_Scaler_Start, o_Adder_Start  out  2  strobes, bit selected by o_Harmonic[0]; o_Busy  out  1; o_Overrun, o_Timeout  out  1  sticky flags; o_Overrun_Count  out  8.

Function
REQ-010 Sample timer SHALL count 0..SAMPLE_INTERVAL-1 and wrap; tick asserted on the cycle count equals SAMPLE_INTERVAL-1.
REQ-011 States SHALL be: IDLE, SCALE_START, SCALE_WAIT, SAMPLE_WAIT, NEXT, CALC_DONE, CLEAR, SEND_WAIT.
REQ-012 IDLE: on tick with i_Enable=1 -> pulse o_Scaler_Restart and o_Next_Sample, o_Harmonic<=0, latch limit -> SCALE_START; no o_DAC_Send from IDLE.
REQ-013 Effective limit SHALL be min(i_Harmonic_Limit, NO_OF_HARMONICS), value 0 treated as 1, latched only at frame start.
REQ-014 SCALE_START: pulse o_Scaler_Start[o_Harmonic[0]] one cycle -> SCALE_WAIT.
REQ-015 SCALE_WAIT: when i_Scaler_Ready[o_Harmonic[0]]=1 -> SAMPLE_WAIT.
REQ-016 SAMPLE_WAIT: when i_Sample_Ready=1 pulse o_Adder_Start[o_Harmonic[0]] one cycle -> NEXT.
REQ-017 NEXT: o_Harmonic<=o_Harmonic+1, pulse o_Next_Sample; if o_Harmonic+1 >= limit or i_Freq_Too_High=1 -> CALC_DONE, else SCALE_START.
REQ-018 CALC_DONE: pulse o_Total_Latch -> CLEAR; CLEAR: pulse o_Adder_Clear -> SEND_WAIT (clear always one cycle after latch).
REQ-019 SEND_WAIT: on tick pulse o_DAC_Send and perform REQ-012 start actions same cycle if i_Enable=1, else -> IDLE after the o_DAC_Send pulse.
REQ-020 Tick in any state other than IDLE/SEND_WAIT SHALL be an overrun: set o_Overrun, increment o_Overrun_Count (saturate at 255), abort loop -> CALC_DONE; no o_DAC_Send for that tick.
REQ-021 Wait counter SHALL reset on each state entry; exceeding WAIT_TIMEOUT cycles in SCALE_WAIT or SAMPLE_WAIT -> set o_Timeout, -> CALC_DONE.
REQ-022 Tick coinciding with a timeout SHALL count as overrun and timeout both; single transition to CALC_DONE.
REQ-023 o_Busy SHALL be 1 in all states except IDLE and SEND_WAIT.
REQ-024 o_Harmonic SHALL never exceed NO_OF_HARMONICS; strobes SHALL never exceed one cycle.
REQ-025 i_Enable deasserted mid-frame SHALL not abort the frame; effect only at next start decision.

Reset
REQ-026 While i_Reset_n=0: state IDLE, timer 0, o_Harmonic 0, all strobes 0, o_Busy 0, o_Overrun 0, o_Timeout 0, o_Overrun_Count 0.
REQ-027 Reset assertion mid-frame SHALL take effect immediately (asynchronous); first tick after release at cycle SAMPLE_INTERVAL-1.
REQ-028 Sticky flags SHALL clear only by reset.

Verification
REQ-029 Ready inputs tied 1, limit 100, enable 1 -> frame start at cycle 999; 100 o_Adder_Start pulses alternating bit 0/1; CALC_DONE 400 cycles after start; o_DAC_Send at cycle 1999.
REQ-030 i_Freq_Too_High raised during harmonic 10 -> exactly 11 adder starts, o_Total_Latch then o_Adder_Clear on consecutive cycles.
REQ-031 i_Sample_Ready held 0 -> o_Timeout=1 after 256 wait cycles, latch/clear issued, no overrun.
REQ-032 i_Scaler_Ready delayed 10 cycles each, limit 100 -> tick mid-loop: o_Overrun=1, count 1, no o_DAC_Send that tick, o_DAC_Send at following tick.
REQ-033 i_Harmonic_Limit=0 -> one harmonic processed; i_Harmonic_Limit=200 -> clamped to 100.
REQ-034 i_Reset_n pulsed low during SCALE_WAIT -> all outputs 0 in same cycle, restart at cycle 999 after release.

Source files
------------

// File: rtl/harmonic_sequencer_if.sv
// rtl/harmonic_sequencer_if.sv - handshake bundle between the harmonic sequencer and its datapath
interface harmonic_sequencer_if;
    logic       i_Enable;
    logic [7:0] i_Harmonic_Limit;
    logic [1:0] i_Scaler_Ready;
    logic       i_Sample_Ready;
    logic       i_Freq_Too_High;
    logic [7:0] o_Harmonic;
    logic       o_Next_Sample;
    logic       o_Scaler_Restart;
    logic       o_Adder_Clear;
    logic       o_Total_Latch;
    logic       o_DAC_Send;
    logic [1:0] o_Scaler_Start;
    logic [1:0] o_Adder_Start;
    logic       o_Busy;
    logic       o_Overrun;
    logic       o_Timeout;
    logic [7:0] o_Overrun_Count;

    modport slave (
        input  i_Enable, i_Harmonic_Limit, i_Scaler_Ready, i_Sample_Ready, i_Freq_Too_High,
        output o_Harmonic, o_Next_Sample, o_Scaler_Restart, o_Adder_Clear, o_Total_Latch,
               o_DAC_Send, o_Scaler_Start, o_Adder_Start, o_Busy, o_Overrun, o_Timeout,
               o_Overrun_Count
    );

    modport master (
        output i_Enable, i_Harmonic_Limit, i_Scaler_Ready, i_Sample_Ready, i_Freq_Too_High,
        input  o_Harmonic, o_Next_Sample, o_Scaler_Restart, o_Adder_Clear, o_Total_Latch,
               o_DAC_Send, o_Scaler_Start, o_Adder_Start, o_Busy, o_Overrun, o_Timeout,
               o_Overrun_Count
    );
endinterface

// File: rtl/harmonic_sequencer.sv
// rtl/harmonic_sequencer.sv - per-sample harmonic loop sequencer with overrun and wait-timeout guards
module harmonic_sequencer #(
    parameter int SAMPLE_INTERVAL = 1000,
    parameter int NO_OF_HARMONICS = 100,
    parameter int WAIT_TIMEOUT    = 255
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    harmonic_sequencer_if.slave  bus
);
    localparam int TW = $clog2(SAMPLE_INTERVAL);
    localparam int WW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, SCALE_START, SCALE_WAIT, SAMPLE_WAIT, NEXT, CALC_DONE, CLEAR, SEND_WAIT
    } state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [WW-1:0] wait_q;
    logic [7:0]    harmonic_q, harmonic_d;
    logic [7:0]    limit_q, limit_d;
    logic [7:0]    overrun_cnt_q;
    logic          next_sample_q, restart_q, adder_clear_q, total_latch_q, dac_send_q;
    logic [1:0]    scaler_start_q, adder_start_q;
    logic          overrun_q, timeout_q;
    logic          tick, in_loop, waiting, wait_done, wait_expired;
    logic [1:0]    sel_bits;

    assign tick         = (timer_q == TW'(SAMPLE_INTERVAL - 1));
    assign timer_d      = tick ? '0 : timer_q + TW'(1);
    assign harmonic_d   = harmonic_q + 8'd1;
    assign sel_bits     = {harmonic_q[0], ~harmonic_q[0]};
    assign in_loop      = state_q inside {SCALE_START, SCALE_WAIT, SAMPLE_WAIT, NEXT};
    assign waiting      = state_q inside {SCALE_WAIT, SAMPLE_WAIT};
    assign wait_done    = (state_q == SCALE_WAIT) ? bus.i_Scaler_Ready[harmonic_q[0]]
                                                  : bus.i_Sample_Ready;
    assign wait_expired = waiting && !wait_done && (wait_q == WW'(WAIT_TIMEOUT));

    // Clamp the requested count to the build maximum; zero still runs the fundamental.
    always_comb begin
        limit_d = bus.i_Harmonic_Limit;
        if (int'(bus.i_Harmonic_Limit) > NO_OF_HARMONICS) limit_d = 8'(NO_OF_HARMONICS);
        if (limit_d == 8'd0) limit_d = 8'd1;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            wait_q         <= '0;
            harmonic_q     <= '0;
            limit_q        <= 8'd1;
            overrun_cnt_q  <= '0;
            next_sample_q  <= 1'b0;
            restart_q      <= 1'b0;
            adder_clear_q  <= 1'b0;
            total_latch_q  <= 1'b0;
            dac_send_q     <= 1'b0;
            scaler_start_q <= '0;
            adder_start_q  <= '0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            timer_q        <= timer_d;
            // Only the two wait states read this; it is cleared on the way into each of them.
            wait_q         <= wait_q + WW'(1);
            next_sample_q  <= 1'b0;
            restart_q      <= 1'b0;
            adder_clear_q  <= 1'b0;
            total_latch_q  <= 1'b0;
            dac_send_q     <= 1'b0;
            scaler_start_q <= '0;
            adder_start_q  <= '0;

            if (tick && state_q != IDLE && state_q != SEND_WAIT) begin
                overrun_q <= 1'b1;
                if (overrun_cnt_q != 8'hFF) overrun_cnt_q <= overrun_cnt_q + 8'd1;
            end

            // A late tick aborts the loop; the wrap-up states simply finish.
            if (tick && in_loop) begin
                state_q <= CALC_DONE;
                if (wait_expired) timeout_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (tick && bus.i_Enable) begin
                        restart_q     <= 1'b1;
                        next_sample_q <= 1'b1;
                        harmonic_q    <= '0;
                        limit_q       <= limit_d;
                        state_q       <= SCALE_START;
                    end
                    SCALE_START: begin
                        scaler_start_q <= sel_bits;
                        wait_q         <= '0;
                        state_q        <= SCALE_WAIT;
                    end
                    SCALE_WAIT: if (wait_done) begin
                        wait_q  <= '0;
                        state_q <= SAMPLE_WAIT;
                    end else if (wait_expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= CALC_DONE;
                    end
                    SAMPLE_WAIT: if (wait_done) begin
                        adder_start_q <= sel_bits;
                        state_q       <= NEXT;
                    end else if (wait_expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= CALC_DONE;
                    end
                    NEXT: begin
                        harmonic_q    <= harmonic_d;
                        next_sample_q <= 1'b1;
                        state_q <= (harmonic_d >= limit_q || bus.i_Freq_Too_High) ? CALC_DONE
                                                                                  : SCALE_START;
                    end
                    CALC_DONE: begin
                        total_latch_q <= 1'b1;
                        state_q       <= CLEAR;
                    end
                    CLEAR: begin
                        adder_clear_q <= 1'b1;
                        state_q       <= SEND_WAIT;
                    end
                    SEND_WAIT: if (tick) begin
                        dac_send_q <= 1'b1;
                        if (bus.i_Enable) begin
                            restart_q     <= 1'b1;
                            next_sample_q <= 1'b1;
                            harmonic_q    <= '0;
                            limit_q       <= limit_d;
                            state_q       <= SCALE_START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_Harmonic       = harmonic_q;
    assign bus.o_Next_Sample    = next_sample_q;
    assign bus.o_Scaler_Restart = restart_q;
    assign bus.o_Adder_Clear    = adder_clear_q;
    assign bus.o_Total_Latch    = total_latch_q;
    assign bus.o_DAC_Send       = dac_send_q;
    assign bus.o_Scaler_Start   = scaler_start_q;
    assign bus.o_Adder_Start    = adder_start_q;
    assign bus.o_Busy           = !(state_q == IDLE || state_q == SEND_WAIT);
    assign bus.o_Overrun        = overrun_q;
    assign bus.o_Timeout        = timeout_q;
    assign bus.o_Overrun_Count  = overrun_cnt_q;
endmodule

// File: tb/tb_harmonic_sequencer.sv
// tb/tb_harmonic_sequencer.sv - randomized self-checking bench for harmonic_sequencer
module tb_harmonic_sequencer;
    localparam int SI    = 1000;
    localparam int NH    = 100;
    localparam int WT    = 255;
    localparam int NEVER = 100000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    harmonic_sequencer_if sif();

    harmonic_sequencer #(
        .SAMPLE_INTERVAL(SI), .NO_OF_HARMONICS(NH), .WAIT_TIMEOUT(WT)
    ) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (sif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Cycle index of the current clock period, counted from reset release.
    int cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    int cfg_ds, cfg_da, cfg_fidx;
    int restarts, rs1, rs2, adds1, harm1, ns1, latches, latch1, clear1, dacs, dac1, busy1, bit_err;

    // Datapath responder plus event recorder; readiness is timed from each scaler start.
    initial begin
        int   sstarts, adds, wcnt;
        logic active, rbit, freq_hi;
        sstarts = 0; adds = 0; wcnt = 0; active = 1'b0; rbit = 1'b0; freq_hi = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                restarts = 0; rs1 = -1; rs2 = -1; adds1 = 0; harm1 = -1; ns1 = 0;
                latches = 0; latch1 = -1; clear1 = -1; dacs = 0; dac1 = -1; busy1 = 0;
                bit_err = 0; sstarts = 0; adds = 0; active = 1'b0; freq_hi = 1'b0;
                sif.i_Scaler_Ready  = 2'b00;
                sif.i_Sample_Ready  = 1'b0;
                sif.i_Freq_Too_High = 1'b0;
            end else begin
                if (sif.o_Scaler_Restart) begin
                    restarts++;
                    if (restarts == 1) rs1 = cyc;
                    else if (restarts == 2) rs2 = cyc;
                    sstarts = 0; adds = 0; active = 1'b0; freq_hi = 1'b0;
                end
                if (sif.o_Scaler_Start != 2'b00) begin
                    if (sif.o_Scaler_Start != ((sstarts % 2) != 0 ? 2'b10 : 2'b01)) bit_err++;
                    rbit = sif.o_Scaler_Start[1];
                    wcnt = 0;
                    active = 1'b1;
                    if (sstarts == cfg_fidx) freq_hi = 1'b1;
                    sstarts++;
                end else if (active) begin
                    wcnt++;
                end
                if (sif.o_Adder_Start != 2'b00) begin
                    if (sif.o_Adder_Start != ((adds % 2) != 0 ? 2'b10 : 2'b01)) bit_err++;
                    adds++;
                    if (restarts == 1 && latches == 0) adds1++;
                end
                if (sif.o_Next_Sample && restarts == 1 && latches == 0) ns1++;
                if (restarts == 1 && dacs == 0 && sif.o_Busy) busy1++;
                if (sif.o_Total_Latch) begin
                    if (latches == 0) begin latch1 = cyc; harm1 = int'(sif.o_Harmonic); end
                    latches++;
                end
                if (sif.o_Adder_Clear && clear1 < 0) clear1 = cyc;
                if (sif.o_DAC_Send) begin
                    if (dacs == 0) dac1 = cyc;
                    dacs++;
                end
                sif.i_Scaler_Ready  = (active && wcnt >= cfg_ds) ? {rbit, ~rbit} : 2'b00;
                sif.i_Sample_Ready  = active && (wcnt >= cfg_ds + 1 + cfg_da);
                sif.i_Freq_Too_High = freq_hi;
            end
        end
    end

    typedef struct {
        int calc; int adds; int harm; int ov; int to; int dac; int bad;
    } exp_t;

    // Frame outcome from the timing rules: each harmonic costs ds+da+4 cycles after the
    // start decision at cycle SI-1; the next tick lands at SI-1+SI.
    function automatic exp_t model(input int lim_in, input int ds, input int da, input int fidx);
        exp_t e;
        int   h, p, t0;
        t0 = SI - 1;
        h  = (lim_in > NH) ? NH : lim_in;
        if (h == 0) h = 1;
        if (fidx < h) h = fidx + 1;
        p = ds + da + 4;
        e.ov = 0; e.to = 0; e.bad = 0;
        if (da > WT) begin
            e.to = 1; e.adds = 0; e.harm = 0; e.calc = t0 + ds + WT + 4;
        end else if (h * p < SI - 2) begin
            e.adds = h; e.harm = h; e.calc = t0 + h * p + 1;
        end else begin
            e.ov   = 1;
            e.adds = (SI / p < h) ? SI / p : h;
            e.harm = ((SI - 1) / p < h) ? (SI - 1) / p : h;
            e.calc = t0 + SI + 1;
            e.bad  = (h * p < SI) ? 1 : 0;
        end
        e.dac = t0 + (e.ov != 0 ? 2 : 1) * SI + 1;
        return e;
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input string nm, input int lim, input int ds, input int da,
                       input int fidx, input bit en_drop, input int rst_at);
        exp_t e;
        e = model(lim, ds, da, fidx);
        cfg_ds = ds; cfg_da = da; cfg_fidx = fidx;
        sif.i_Enable         = 1'b1;
        sif.i_Harmonic_Limit = 8'(lim);
        do_reset();
        if (rst_at > 0) begin
            wait_cyc(rst_at);
            check($sformatf("%s.busy_pre", nm), int'(sif.o_Busy), 1);
            rst_n = 1'b0;
            #1;
            check($sformatf("%s.rst_zero", nm),
                  int'({sif.o_Harmonic, sif.o_Next_Sample, sif.o_Scaler_Restart, sif.o_Adder_Clear,
                        sif.o_Total_Latch, sif.o_DAC_Send, sif.o_Scaler_Start, sif.o_Adder_Start,
                        sif.o_Busy, sif.o_Overrun, sif.o_Timeout, sif.o_Overrun_Count}), 0);
            do_reset();
        end
        if (en_drop) begin
            wait_cyc(SI + 2);
            sif.i_Enable         = 1'b0;
            sif.i_Harmonic_Limit = 8'd1;
        end
        wait_cyc(e.dac + 2);
        check($sformatf("%s.start", nm),   rs1,     SI);
        check($sformatf("%s.adds", nm),    adds1,   e.adds);
        check($sformatf("%s.harm", nm),    harm1,   e.harm);
        check($sformatf("%s.nsamp", nm),   ns1,     e.harm + 1);
        check($sformatf("%s.latch", nm),   latch1,  e.calc + 1);
        check($sformatf("%s.clear", nm),   clear1,  e.calc + 2);
        check($sformatf("%s.dac", nm),     dac1,    e.dac);
        check($sformatf("%s.busy", nm),    busy1,   e.calc + 1 - (SI - 1));
        check($sformatf("%s.ovr", nm),     int'(sif.o_Overrun),       e.ov);
        check($sformatf("%s.ovr_cnt", nm), int'(sif.o_Overrun_Count), e.ov);
        check($sformatf("%s.tmo", nm),     int'(sif.o_Timeout),       e.to);
        check($sformatf("%s.bits", nm),    bit_err, 0);
        if (en_drop) begin
            wait_cyc(e.dac + SI + 2);
            check($sformatf("%s.restarts", nm), restarts, 1);
            check($sformatf("%s.dacs", nm),     dacs,     1);
            check($sformatf("%s.idle", nm),     int'(sif.o_Busy), 0);
        end else begin
            check($sformatf("%s.restart2", nm), rs2, e.dac);
        end
    endtask

    initial begin
        exp_t e;
        int   lim, ds, da, fidx;
        sif.i_Enable         = 1'b0;
        sif.i_Harmonic_Limit = 8'd0;
        cfg_ds = 0; cfg_da = 0; cfg_fidx = NEVER;
        run("full",    100, 0,  0,     NEVER, 1'b0, 0);
        run("nyquist", 100, 0,  0,     10,    1'b0, 0);
        run("timeout", 100, 0,  NEVER, NEVER, 1'b0, 0);
        run("overrun", 100, 10, 0,     NEVER, 1'b0, 0);
        run("lim0",    0,   0,  0,     NEVER, 1'b0, 0);
        run("lim200",  200, 0,  0,     NEVER, 1'b0, 0);
        run("rstmid",  100, 10, 0,     NEVER, 1'b0, 1050);
        run("endrop",  100, 3,  2,     NEVER, 1'b1, 0);
        for (int i = 0; i < 6; i++) begin
            do begin
                lim  = $urandom_range(0, 255);
                ds   = $urandom_range(0, 8);
                da   = $urandom_range(0, 8);
                fidx = $urandom_range(0, 150);
                e    = model(lim, ds, da, fidx);
            end while (e.bad != 0);
            run($sformatf("rand%0d", i), lim, ds, da, fidx, 1'b0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
